// File: rtl/pool_channel_sequencer_if.sv
// Bus between the layer controller / feature-map buffers / pooler (master side)
// and the channel sequencer (slave side).
interface pool_channel_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pool_rst;
  logic                  pool_ce;
  logic [DATA_WIDTH-1:0] pool_data_in;
  logic [DATA_WIDTH-1:0] pool_data_out;
  logic                  pool_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output start, src_base, dst_base, rd_data, pool_data_out, pool_valid,
    input  busy, done, err, rd_en, rd_addr, pool_rst, pool_ce, pool_data_in,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, src_base, dst_base, rd_data, pool_data_out, pool_valid,
    output busy, done, err, rd_en, rd_addr, pool_rst, pool_ce, pool_data_in,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_channel_sequencer.sv
// Walks NUM_CH channels of a feature map through one pooler: clear, stream the
// pixels in raster order, then collect the pooled results into the destination buffer.
module pool_channel_sequencer #(
  parameter int INPUT_SIZE    = 4,
  parameter int POOL_SIZE     = 2,
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int DRAIN_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    master_rst,
  pool_channel_sequencer_if.slave bus
);

  localparam int OUT_SIZE = INPUT_SIZE / POOL_SIZE;
  localparam int NUM_PIX  = INPUT_SIZE * INPUT_SIZE;
  localparam int NUM_OUT  = OUT_SIZE * OUT_SIZE;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PIX_W    = $clog2(NUM_PIX + 1);
  localparam int OUT_W    = $clog2(NUM_OUT + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(NUM_PIX - 1);
  localparam logic [OUT_W-1:0]   OUT_FULL   = OUT_W'(NUM_OUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  if ((INPUT_SIZE % POOL_SIZE) != 0 || NUM_CH < 1) begin : g_param_check
    $error("pool_channel_sequencer: INPUT_SIZE must be a multiple of POOL_SIZE and NUM_CH >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t                state;
  logic [CH_W-1:0]       ch;
  logic [PIX_W-1:0]      pix;
  logic [OUT_W-1:0]      out_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [ADDR_WIDTH-1:0] src_base_q;
  logic [ADDR_WIDTH-1:0] dst_base_q;
  logic [ADDR_WIDTH-1:0] ch_src_off;
  logic [ADDR_WIDTH-1:0] ch_dst_off;
  logic                  capture_window;

  // Per-channel offsets wrap modulo 2^ADDR_WIDTH along with the base addition.
  assign ch_src_off     = ADDR_WIDTH'(int'(ch) * NUM_PIX);
  assign ch_dst_off     = ADDR_WIDTH'(int'(ch) * NUM_OUT);
  assign capture_window = (state == S_STREAM) || (state == S_DRAIN);

  assign bus.pool_data_in = bus.rd_data;

  // NOTE: every register here uses <= so all of them see the pre-edge values of
  // one another; a blocking = would make later statements read half-updated state.
  always_ff @(posedge clk) begin
    if (master_rst) begin
      state         <= S_IDLE;
      ch            <= '0;
      pix           <= '0;
      out_cnt       <= '0;
      drain_cnt     <= '0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.pool_rst  <= 1'b1;
      bus.pool_ce   <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
    end else begin
      // The pooler consumes rd_data, which lags rd_en by one cycle.
      bus.pool_ce <= bus.rd_en;
      bus.done    <= 1'b0;
      bus.wr_en   <= 1'b0;

      if (capture_window && bus.pool_valid) begin
        if (out_cnt < OUT_FULL) begin
          bus.wr_en   <= 1'b1;
          bus.wr_data <= bus.pool_data_out;
          bus.wr_addr <= dst_base_q + ch_dst_off + ADDR_WIDTH'(out_cnt);
          out_cnt     <= out_cnt + 1'b1;
        end else begin
          bus.err <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          bus.pool_rst <= 1'b1;
          if (bus.start) begin
            src_base_q <= bus.src_base;
            dst_base_q <= bus.dst_base;
            ch         <= '0;
            bus.err    <= 1'b0;
            bus.busy   <= 1'b1;
            state      <= S_CLR;
          end
        end

        S_CLR: begin
          pix          <= '0;
          out_cnt      <= '0;
          drain_cnt    <= '0;
          bus.pool_rst <= 1'b0;
          bus.rd_en    <= 1'b1;
          bus.rd_addr  <= src_base_q + ch_src_off;
          state        <= S_STREAM;
        end

        S_STREAM: begin
          if (pix == PIX_LAST) begin
            bus.rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            pix         <= pix + 1'b1;
            bus.rd_addr <= bus.rd_addr + 1'b1;
          end
        end

        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          // out_cnt and wr_en advance on the same edge, so a full count means the
          // last write is already on the bus and nothing is left pending.
          if (out_cnt == OUT_FULL) begin
            state <= S_NEXT;
          end else if (drain_cnt == DRAIN_LAST) begin
            bus.err <= 1'b1;
            state   <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (ch == CH_LAST) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            ch           <= ch + 1'b1;
            bus.pool_rst <= 1'b1;
            state        <= S_CLR;
          end
        end

        S_DONE: begin
          bus.busy     <= 1'b0;
          bus.pool_rst <= 1'b1;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
